sched_ctrl_multi: RTL and testbench

SCHED_CTRL_MULTI -- requirements
Module: sched_ctrl_multi

---
 rtl/sched_pkg.sv | 21 ++
 rtl/sched_chan_trk.sv | 60 ++++++
 rtl/sched_ctrl_multi.sv | 130 +++++++++++++
 tb/tb_sched_ctrl_multi.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared scheduler definitions: master-FSM encodings, scheduler states and the
// default store-engine acknowledge timeout. Also consumed by fsm64.
package sched_pkg;

  localparam logic [2:0] M_IDLE  = 3'd0;
  localparam logic [2:0] M_LEFT  = 3'd1;
  localparam logic [2:0] M_BASE  = 3'd2;
  localparam logic [2:0] M_RIGHT = 3'd3;
  localparam logic [2:0] M_FSLD  = 3'd7;

  localparam int ACK_TMO_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_NEXT  = 3'd3,
    S_FIN   = 3'd4
  } sched_state_t;

endpackage

// File: rtl/sched_chan_trk.sv
// Per-channel tracker: remembers that a store was issued, watches for the
// engine's busy acknowledge and marks the channel complete on done or timeout.
module sched_chan_trk
  import sched_pkg::*;
#(
  parameter int ACK_TMO = ACK_TMO_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  input  logic clr,
  input  logic busy,
  input  logic done,
  output logic issued,
  output logic cmpl,
  output logic fin_now,
  output logic tmo
);

  localparam int CW = $clog2(ACK_TMO + 1);

  logic          acked;
  logic [CW-1:0] ack_cnt;
  logic          waiting;

  assign waiting = issued & ~cmpl;
  // The count covers the ACK_TMO cycles following the start pulse; the last
  // one without busy is the timeout cycle, which also completes the channel.
  assign tmo     = waiting & ~acked & ~busy & (ack_cnt == CW'(ACK_TMO - 1));
  assign fin_now = waiting & ((done & busy) | tmo);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      issued  <= 1'b0;
      cmpl    <= 1'b0;
      acked   <= 1'b0;
      ack_cnt <= '0;
    end else if (start) begin
      issued  <= 1'b1;
      cmpl    <= 1'b0;
      acked   <= 1'b0;
      ack_cnt <= '0;
    end else if (clr) begin
      issued  <= 1'b0;
      cmpl    <= 1'b0;
      acked   <= 1'b0;
      ack_cnt <= '0;
    end else if (waiting) begin
      if (busy)
        acked <= 1'b1;
      else if (!acked)
        ack_cnt <= ack_cnt + CW'(1);
      if (fin_now)
        cmpl <= 1'b1;
    end
  end

endmodule

// File: rtl/sched_ctrl_multi.sv
// Store scheduler: on FSLD or BASE entry of the master FSM it issues store
// jobs on the masked channels, in parallel or one at a time, then flags the end.
module sched_ctrl_multi
  import sched_pkg::*;
#(
  parameter int NCH     = 3,
  parameter int RND_W   = 8,
  parameter int ACK_TMO = ACK_TMO_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [2:0]       mast_curr_state,
  input  logic [NCH-1:0]   cfg_fsld_mask,
  input  logic [NCH-1:0]   cfg_base_mask,
  input  logic             cfg_par_mode,
  input  logic [RND_W-1:0] cfg_base_rounds,
  input  logic [NCH-1:0]   store_busy,
  input  logic [NCH-1:0]   store_done,
  output logic [NCH-1:0]   start_store,
  output logic             flag_fsld_end,
  output logic             flag_base_end,
  output logic             sched_busy,
  output logic             sched_err
);

  sched_state_t     state_q, state_d;
  logic [2:0]       mast_q;
  logic             job_base_q;
  logic             par_q;
  logic [NCH-1:0]   base_mask_q;
  logic [NCH-1:0]   pending_q;
  logic [RND_W-1:0] rounds_q;
  logic [RND_W-1:0] round_cnt_q;

  logic             trig_fsld, trig_base, trig;
  logic [NCH-1:0]   issue_sel;
  logic [NCH-1:0]   trk_issued, trk_cmpl, trk_fin, trk_tmo;
  logic             all_done;
  logic [RND_W:0]   rnd_next;
  logic             last_round;

  assign trig_fsld = (mast_curr_state == M_FSLD) && (mast_q != M_FSLD);
  assign trig_base = (mast_curr_state == M_BASE) && (mast_q != M_BASE);
  assign trig      = trig_fsld | trig_base;

  // Including this cycle's completions keeps done-to-flag latency at two.
  assign all_done   = &(~trk_issued | trk_cmpl | trk_fin);
  // A programmed round count of zero falls out as a single round here.
  assign rnd_next   = {1'b0, round_cnt_q} + (RND_W + 1)'(1);
  assign last_round = ~job_base_q | (rnd_next >= {1'b0, rounds_q});

  // NOTE: every combinational output gets a default first so no path through
  // the block leaves it unassigned and infers a latch.
  always_comb begin
    issue_sel = '0;
    if (state_q == S_ISSUE)
      issue_sel = par_q ? pending_q : (pending_q & (~pending_q + NCH'(1)));
  end

  for (genvar i = 0; i < NCH; i++) begin : g_trk
    sched_chan_trk #(.ACK_TMO(ACK_TMO)) u_trk (
      .clk     (clk),
      .rstn    (rstn),
      .start   (issue_sel[i]),
      .clr     (state_q == S_NEXT),
      .busy    (store_busy[i]),
      .done    (store_done[i]),
      .issued  (trk_issued[i]),
      .cmpl    (trk_cmpl[i]),
      .fin_now (trk_fin[i]),
      .tmo     (trk_tmo[i])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (trig) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (all_done) state_d = S_NEXT;
      S_NEXT:  state_d = ((pending_q != '0) || !last_round) ? S_ISSUE : S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mast_q      <= M_IDLE;
      job_base_q  <= 1'b0;
      par_q       <= 1'b0;
      base_mask_q <= '0;
      pending_q   <= '0;
      rounds_q    <= '0;
      round_cnt_q <= '0;
      sched_err   <= 1'b0;
    end else begin
      mast_q <= mast_curr_state;
      if ((trig && state_q != S_IDLE) || (|trk_tmo))
        sched_err <= 1'b1;
      case (state_q)
        S_IDLE: if (trig) begin
          job_base_q  <= trig_base;
          par_q       <= cfg_par_mode;
          base_mask_q <= cfg_base_mask;
          pending_q   <= trig_base ? cfg_base_mask : cfg_fsld_mask;
          rounds_q    <= cfg_base_rounds;
          round_cnt_q <= '0;
        end
        S_ISSUE: pending_q <= pending_q & ~issue_sel;
        S_NEXT: if (pending_q == '0 && !last_round) begin
          round_cnt_q <= rnd_next[RND_W-1:0];
          pending_q   <= base_mask_q;
        end
        default: ;
      endcase
    end
  end

  assign start_store   = issue_sel;
  assign flag_fsld_end = (state_q == S_FIN) && !job_base_q;
  assign flag_base_end = (state_q == S_FIN) && job_base_q;
  assign sched_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_sched_ctrl_multi.sv
// Directed bench for sched_ctrl_multi: behavioural store engines, a per-cycle
// monitor sampled on the falling edge, and one task per scenario.
module tb_sched_ctrl_multi;
  import sched_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic [2:0] mast_curr_state;
  logic [2:0] cfg_fsld_mask, cfg_base_mask;
  logic       cfg_par_mode;
  logic [7:0] cfg_base_rounds;
  logic [2:0] store_busy, store_done;
  logic [2:0] start_store;
  logic       flag_fsld_end, flag_base_end, sched_busy, sched_err;

  sched_ctrl_multi #(.NCH(3), .RND_W(8), .ACK_TMO(16)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .mast_curr_state (mast_curr_state),
    .cfg_fsld_mask   (cfg_fsld_mask),
    .cfg_base_mask   (cfg_base_mask),
    .cfg_par_mode    (cfg_par_mode),
    .cfg_base_rounds (cfg_base_rounds),
    .store_busy      (store_busy),
    .store_done      (store_done),
    .start_store     (start_store),
    .flag_fsld_end   (flag_fsld_end),
    .flag_base_end   (flag_base_end),
    .sched_busy      (sched_busy),
    .sched_err       (sched_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // monitor / engine state, all owned by the single stimulus process
  int cyc = 0;
  int n_start[3], first_start[3], last_start[3];
  int eng_t[3], dly[3];
  bit eng_on[3], nobusy[3];
  int max_par, max_busy, n_ff, n_fb, ff_cyc, fb_cyc, err_cyc;

  task automatic clear_mon();
    for (int i = 0; i < 3; i++) begin
      n_start[i] = 0; first_start[i] = -1; last_start[i] = -1;
    end
    max_par = 0; max_busy = 0; n_ff = 0; n_fb = 0;
    ff_cyc = -1; fb_cyc = -1; err_cyc = -1;
  endtask

  // One clock: sample DUT outputs at the falling edge, then drive engines.
  // An engine raises busy the cycle after its start and pulses done (with busy
  // still high) dly cycles after busy first rose.
  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (start_store[i]) begin
        n_start[i]++;
        if (first_start[i] < 0) first_start[i] = cyc;
        last_start[i] = cyc;
        eng_on[i] = 1'b1;
        eng_t[i]  = 0;
      end else if (eng_on[i]) begin
        eng_t[i]++;
      end
    end
    if ($countones(start_store) > max_par) max_par = $countones(start_store);
    if (flag_fsld_end) begin n_ff++; ff_cyc = cyc; end
    if (flag_base_end) begin n_fb++; fb_cyc = cyc; end
    if (sched_err && err_cyc < 0) err_cyc = cyc;
    for (int i = 0; i < 3; i++) begin
      if (!rstn) eng_on[i] = 1'b0;
      store_busy[i] = eng_on[i] && !nobusy[i] && eng_t[i] >= 1 && eng_t[i] <= dly[i] + 1;
      store_done[i] = eng_on[i] && !nobusy[i] && eng_t[i] == dly[i] + 1;
      if (eng_on[i] && eng_t[i] > dly[i] + 1) eng_on[i] = 1'b0;
    end
    if ($countones(store_busy) > max_busy) max_busy = $countones(store_busy);
  endtask

  // Drive a master-state entry; returns the cycle in which the FSM sits in S_ISSUE.
  task automatic trigger(input logic [2:0] st, output int t0);
    mast_curr_state = st;
    t0 = cyc + 1;
    tick();
    mast_curr_state = M_IDLE;
  endtask

  task automatic run_to_flag();
    for (int k = 0; k < 300 && (n_ff + n_fb) == 0; k++) tick();
    repeat (6) tick();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    mast_curr_state = M_IDLE;
    repeat (2) tick();
    rstn = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) tick();
    tests++; if (start_store !== 3'b000) begin fails++; $display("FAIL rst_start: got %b expected 000", start_store); end
    tests++; if (sched_busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b expected 0", sched_busy); end
    tests++; if (sched_err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b expected 0", sched_err); end
    tests++; if ({flag_fsld_end, flag_base_end} !== 2'b00) begin fails++; $display("FAIL rst_flags: got %b expected 00", {flag_fsld_end, flag_base_end}); end
    rstn = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_fsld_seq();
    int t0;
    cfg_fsld_mask = 3'b111; cfg_par_mode = 1'b0;
    dly = '{15, 15, 15};
    clear_mon();
    trigger(M_FSLD, t0);
    tests++; if (sched_busy !== 1'b1) begin fails++; $display("FAIL seq_busy: got %b expected 1", sched_busy); end
    run_to_flag();
    tests++; if (first_start[0] !== t0) begin fails++; $display("FAIL seq_start0: got %0d expected %0d", first_start[0], t0); end
    tests++; if (first_start[1] !== t0 + 18) begin fails++; $display("FAIL seq_start1: got %0d expected %0d", first_start[1], t0 + 18); end
    tests++; if (first_start[2] !== t0 + 36) begin fails++; $display("FAIL seq_start2: got %0d expected %0d", first_start[2], t0 + 36); end
    tests++; if (n_start[0] + n_start[1] + n_start[2] !== 3) begin fails++; $display("FAIL seq_nstart: got %0d expected 3", n_start[0] + n_start[1] + n_start[2]); end
    tests++; if (max_busy !== 1) begin fails++; $display("FAIL seq_overlap: got %0d busy engines expected 1", max_busy); end
    tests++; if (n_ff !== 1 || n_fb !== 0) begin fails++; $display("FAIL seq_nflag: got %0d/%0d expected 1/0", n_ff, n_fb); end
    tests++; if (ff_cyc !== t0 + 54) begin fails++; $display("FAIL seq_flag_cyc: got %0d expected %0d", ff_cyc, t0 + 54); end
  endtask

  task automatic test_fsld_par();
    int t0;
    cfg_fsld_mask = 3'b111; cfg_par_mode = 1'b1;
    dly = '{15, 20, 10};
    clear_mon();
    trigger(M_FSLD, t0);
    run_to_flag();
    tests++; if (max_par !== 3) begin fails++; $display("FAIL par_width: got %0d expected 3", max_par); end
    tests++; if (first_start[0] !== t0 || first_start[1] !== t0 || first_start[2] !== t0) begin fails++; $display("FAIL par_start: got %0d %0d %0d expected %0d", first_start[0], first_start[1], first_start[2], t0); end
    tests++; if (n_start[0] + n_start[1] + n_start[2] !== 3) begin fails++; $display("FAIL par_nstart: got %0d expected 3", n_start[0] + n_start[1] + n_start[2]); end
    tests++; if (n_ff !== 1 || ff_cyc !== t0 + 23) begin fails++; $display("FAIL par_flag: got %0d at %0d expected 1 at %0d", n_ff, ff_cyc, t0 + 23); end
  endtask

  task automatic test_base_rounds();
    int t0;
    cfg_base_mask = 3'b010; cfg_base_rounds = 8'd5; cfg_par_mode = 1'b0;
    dly = '{15, 15, 15};
    clear_mon();
    trigger(M_BASE, t0);
    cfg_base_mask = 3'b111; cfg_base_rounds = 8'd1;
    run_to_flag();
    tests++; if (n_start[1] !== 5) begin fails++; $display("FAIL base_n1: got %0d expected 5", n_start[1]); end
    tests++; if (n_start[0] + n_start[2] !== 0) begin fails++; $display("FAIL base_other: got %0d expected 0", n_start[0] + n_start[2]); end
    tests++; if (last_start[1] !== t0 + 72) begin fails++; $display("FAIL base_last_start: got %0d expected %0d", last_start[1], t0 + 72); end
    tests++; if (n_fb !== 1 || n_ff !== 0) begin fails++; $display("FAIL base_nflag: got %0d/%0d expected 1/0", n_fb, n_ff); end
    tests++; if (fb_cyc !== t0 + 90) begin fails++; $display("FAIL base_flag_cyc: got %0d expected %0d", fb_cyc, t0 + 90); end
  endtask

  task automatic test_rounds_zero();
    int t0;
    cfg_base_mask = 3'b001; cfg_base_rounds = 8'd0;
    clear_mon();
    trigger(M_BASE, t0);
    run_to_flag();
    tests++; if (n_start[0] !== 1) begin fails++; $display("FAIL rnd0_nstart: got %0d expected 1", n_start[0]); end
    tests++; if (n_fb !== 1 || fb_cyc !== t0 + 18) begin fails++; $display("FAIL rnd0_flag: got %0d at %0d expected 1 at %0d", n_fb, fb_cyc, t0 + 18); end
  endtask

  task automatic test_ack_timeout();
    int t0;
    cfg_fsld_mask = 3'b100; cfg_par_mode = 1'b0;
    nobusy = '{0, 0, 1};
    clear_mon();
    trigger(M_FSLD, t0);
    run_to_flag();
    tests++; if (first_start[2] !== t0) begin fails++; $display("FAIL tmo_start: got %0d expected %0d", first_start[2], t0); end
    tests++; if (err_cyc !== t0 + 17) begin fails++; $display("FAIL tmo_err_cyc: got %0d expected %0d", err_cyc, t0 + 17); end
    tests++; if (n_ff !== 1 || ff_cyc !== t0 + 18) begin fails++; $display("FAIL tmo_flag: got %0d at %0d expected 1 at %0d", n_ff, ff_cyc, t0 + 18); end
    tests++; if (sched_err !== 1'b1) begin fails++; $display("FAIL tmo_sticky: got %b expected 1", sched_err); end
    nobusy = '{0, 0, 0};
  endtask

  task automatic test_empty_and_drop();
    int t0, t1;
    do_reset();
    cfg_fsld_mask = 3'b000;
    clear_mon();
    trigger(M_FSLD, t0);
    run_to_flag();
    tests++; if (n_ff !== 1 || ff_cyc !== t0 + 3) begin fails++; $display("FAIL empty_flag: got %0d at %0d expected 1 at %0d", n_ff, ff_cyc, t0 + 3); end
    tests++; if (n_start[0] + n_start[1] + n_start[2] !== 0) begin fails++; $display("FAIL empty_nstart: got %0d expected 0", n_start[0] + n_start[1] + n_start[2]); end
    tests++; if (err_cyc !== -1) begin fails++; $display("FAIL empty_err: got %0d expected -1", err_cyc); end
    cfg_fsld_mask = 3'b001;
    clear_mon();
    trigger(M_FSLD, t0);
    repeat (3) tick();
    tick();
    trigger(M_FSLD, t1);
    run_to_flag();
    tests++; if (err_cyc !== t1) begin fails++; $display("FAIL drop_err_cyc: got %0d expected %0d", err_cyc, t1); end
    tests++; if (n_start[0] !== 1) begin fails++; $display("FAIL drop_nstart: got %0d expected 1", n_start[0]); end
    tests++; if (n_ff !== 1 || ff_cyc !== t0 + 18) begin fails++; $display("FAIL drop_flag: got %0d at %0d expected 1 at %0d", n_ff, ff_cyc, t0 + 18); end
  endtask

  task automatic test_reset_midjob();
    int t0;
    cfg_fsld_mask = 3'b111; cfg_par_mode = 1'b0;
    clear_mon();
    trigger(M_FSLD, t0);
    repeat (5) tick();
    rstn = 1'b0;
    #1;
    tests++; if (sched_busy !== 1'b0) begin fails++; $display("FAIL mrst_busy: got %b expected 0", sched_busy); end
    tests++; if (sched_err !== 1'b0) begin fails++; $display("FAIL mrst_err: got %b expected 0", sched_err); end
    tests++; if ({start_store, flag_fsld_end, flag_base_end} !== 5'b0) begin fails++; $display("FAIL mrst_outs: got %b expected 00000", {start_store, flag_fsld_end, flag_base_end}); end
    repeat (2) tick();
    rstn = 1'b1;
    clear_mon();
    repeat (60) tick();
    tests++; if (n_ff + n_fb !== 0 || n_start[0] + n_start[1] + n_start[2] !== 0) begin fails++; $display("FAIL mrst_quiet: got %0d flags %0d starts expected 0 0", n_ff + n_fb, n_start[0] + n_start[1] + n_start[2]); end
    cfg_fsld_mask = 3'b001;
    clear_mon();
    trigger(M_FSLD, t0);
    run_to_flag();
    tests++; if (n_start[0] !== 1 || n_ff !== 1 || ff_cyc !== t0 + 18) begin fails++; $display("FAIL mrst_rerun: got %0d starts, %0d flags at %0d expected 1, 1 at %0d", n_start[0], n_ff, ff_cyc, t0 + 18); end
    tests++; if (err_cyc !== -1) begin fails++; $display("FAIL mrst_rerun_err: got %0d expected -1", err_cyc); end
  endtask

  initial begin
    rstn = 1'b0;
    mast_curr_state = M_IDLE;
    cfg_fsld_mask = '0; cfg_base_mask = '0; cfg_par_mode = 1'b0; cfg_base_rounds = '0;
    store_busy = '0; store_done = '0;
    eng_t = '{0, 0, 0}; eng_on = '{0, 0, 0}; nobusy = '{0, 0, 0}; dly = '{15, 15, 15};
    clear_mon();
    test_reset();
    test_fsld_seq();
    test_fsld_par();
    test_base_rounds();
    test_rounds_zero();
    test_ack_timeout();
    test_empty_and_drop();
    test_reset_midjob();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
